// File: rtl/p_pkg.sv
// rtl/p_pkg.sv - shared types and constants for the Poly1305 message feeder
//
// Purpose: FSM state encoding, r clamp mask and block geometry used by
//          p_msg_feed and p_blk_pack.
// Ports:   none (package)

package p_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY_R = 3'd1,
        ST_KEY_S = 3'd2,
        ST_FILL  = 3'd3,
        ST_READY = 3'd4,
        ST_DONE  = 3'd5
    } feed_state_t;

    localparam logic [127:0] R_CLAMP_MASK = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

    localparam int BLK_BYTES = 16;
    localparam int BLK_WORDS = 4;

endpackage

// File: rtl/p_blk_pack.sv
// rtl/p_blk_pack.sv - packs 32-bit stream words into a 128-bit Poly1305 block
//
// Purpose: 4-word pack register with word index; zeroes the tail bytes of the
//          final block according to len%16.
// Ports:
//   clk, rst  clock, async active-high reset
//   clr       clear pack register and word index (block sent / new message)
//   wr        store data at the current word slot and advance the index
//   data      32-bit stream word, byte n at [8n+7:8n]
//   len_lo    message length modulo 16
//   last      current block is the final block of the message
//   idx       word slot the next write lands in
//   blk       packed block, tail-masked when last

module p_blk_pack
    import p_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr,
    input  logic [31:0]  data,
    input  logic [3:0]   len_lo,
    input  logic         last,
    output logic [1:0]   idx,
    output logic [127:0] blk
);

    logic [127:0]          pack;
    logic [BLK_BYTES-1:0]  byte_keep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack <= '0;
            idx  <= '0;
        end else if (clr) begin
            pack <= '0;
            idx  <= '0;
        end else if (wr) begin
            pack[{idx, 5'b00000} +: 32] <= data;
            idx                         <= idx + 2'd1;
        end
    end

    // len%16 == 0 means the final block is full, so nothing is masked.
    // The final stream word may carry junk above the message end, which
    // this mask removes.
    always_comb begin
        byte_keep = '1;
        if (last && (len_lo != 4'd0)) begin
            for (int i = 0; i < BLK_BYTES; i++) begin
                byte_keep[i] = (4'(i) < len_lo);
            end
        end
    end

    always_comb begin
        blk = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            blk[8*i +: 8] = pack[8*i +: 8] & {8{byte_keep[i]}};
        end
    end

endmodule

// File: rtl/p_msg_feed.sv
// rtl/p_msg_feed.sv - message supplier for the Poly1305 tag engine p_tag
//
// Purpose: answers each p_tag request with one strobe carrying r, then s,
//          then the message in zero-padded 16-byte little-endian blocks.
// Build option: P_FEED_CLAMP_EN - clamp r before it is sent.
// Ports:
//   i_clk, i_rst   clock, async active-high reset
//   i_start        one-cycle start; latches i_key and i_len_msg (IDLE only)
//   i_key          {s[127:0], r[127:0]}
//   i_len_msg      message length in bytes
//   i_wr_en        stream word valid
//   i_wr_data      stream word, byte n at [8n+7:8n]
//   o_wr_rdy       stream word accepted this cycle when i_wr_en is high
//   i_rqst_msg     request level from p_tag
//   o_en_msg       one-cycle data strobe
//   o_msg          data, valid in the strobe cycle and held until the next
//   o_len_msg      latched length
//   o_busy         high from start until done
//   o_done         one-cycle pulse after the final strobe

module p_msg_feed
    import p_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [255:0] i_key,
    input  logic [31:0]  i_len_msg,
    input  logic         i_wr_en,
    input  logic [31:0]  i_wr_data,
    output logic         o_wr_rdy,
    input  logic         i_rqst_msg,
    output logic         o_en_msg,
    output logic [127:0] o_msg,
    output logic [31:0]  o_len_msg,
    output logic         o_busy,
    output logic         o_done
);

    feed_state_t  state;
    feed_state_t  state_nxt;

    logic [255:0] key;
    logic [30:0]  words_left;
    logic         served;
    logic         req_edge;

    logic         start_ok;
    logic         take_word;
    logic         last_word;
    logic         last_blk;
    logic         send_key_r;
    logic         send_key_s;
    logic         send_blk;
    logic         send_any;
    logic         pack_clr;

    logic [1:0]   pack_idx;
    logic [127:0] pack_blk;
    logic [127:0] r_out;

    // A request is live while the level is high and no strobe has been
    // issued for it yet; it is therefore held across FILL until READY.
    assign req_edge  = i_rqst_msg && !served;
    assign last_word = (words_left == 31'd1);
    assign last_blk  = (words_left == 31'd0);

`ifdef P_FEED_CLAMP_EN
    assign r_out = key[127:0] & R_CLAMP_MASK;
`else
    assign r_out = key[127:0];
`endif

    p_blk_pack u_pack (
        .clk    (i_clk),
        .rst    (i_rst),
        .clr    (pack_clr),
        .wr     (take_word),
        .data   (i_wr_data),
        .len_lo (o_len_msg[3:0]),
        .last   (last_blk),
        .idx    (pack_idx),
        .blk    (pack_blk)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_start) state_nxt = ST_KEY_R;
            ST_KEY_R: if (req_edge) state_nxt = ST_KEY_S;
            ST_KEY_S: if (req_edge) state_nxt = (o_len_msg == 32'd0) ? ST_DONE : ST_FILL;
            ST_FILL:  if (take_word && ((pack_idx == 2'd3) || last_word)) state_nxt = ST_READY;
            ST_READY: if (req_edge) state_nxt = last_blk ? ST_DONE : ST_FILL;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_wr_rdy   = (state == ST_FILL);
        start_ok   = (state == ST_IDLE) && i_start;
        take_word  = (state == ST_FILL) && i_wr_en;
        send_key_r = (state == ST_KEY_R) && req_edge;
        send_key_s = (state == ST_KEY_S) && req_edge;
        send_blk   = (state == ST_READY) && req_edge;
        send_any   = send_key_r || send_key_s || send_blk;
        pack_clr   = send_blk || start_ok;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            key        <= '0;
            o_len_msg  <= '0;
            words_left <= '0;
            served     <= 1'b0;
            o_en_msg   <= 1'b0;
            o_msg      <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_en_msg <= send_any;
            o_done   <= (state == ST_DONE);
            served   <= i_rqst_msg && (served || send_any);

            if (start_ok) begin
                key        <= i_key;
                o_len_msg  <= i_len_msg;
                // ceil(len/4) stream words
                words_left <= {1'b0, i_len_msg[31:2]} + {30'd0, |i_len_msg[1:0]};
                o_busy     <= 1'b1;
            end else if (state == ST_DONE) begin
                o_busy     <= 1'b0;
            end

            if (take_word) begin
                words_left <= words_left - 31'd1;
            end

            if (send_key_r) begin
                o_msg <= r_out;
            end else if (send_key_s) begin
                o_msg <= key[255:128];
            end else if (send_blk) begin
                o_msg <= pack_blk;
            end
        end
    end

endmodule

// File: tb/tb_p_msg_feed.sv
// tb/tb_p_msg_feed.sv - self-checking bench for p_msg_feed

module tb_p_msg_feed;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] key;
    logic [31:0]  len;
    logic         wr_en;
    logic [31:0]  wr_data;
    logic         wr_rdy;
    logic         rqst;
    logic         en_msg;
    logic [127:0] msg;
    logic [31:0]  len_out;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    p_msg_feed dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_key      (key),
        .i_len_msg  (len),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .o_wr_rdy   (wr_rdy),
        .i_rqst_msg (rqst),
        .o_en_msg   (en_msg),
        .o_msg      (msg),
        .o_len_msg  (len_out),
        .o_busy     (busy),
        .o_done     (done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: message bytes, expected strobe sequence
    logic [7:0]   mb [0:511];
    logic [127:0] exp_q [$];

    function automatic logic [127:0] r_of(input logic [255:0] k);
`ifdef P_FEED_CLAMP_EN
        return k[127:0] & 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
`else
        return k[127:0];
`endif
    endfunction

    function automatic logic [31:0] word_at(input int kk);
        return {mb[4*kk+3], mb[4*kk+2], mb[4*kk+1], mb[4*kk]};
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill_msg();
        for (int i = 0; i < 512; i++) mb[i] = 8'($urandom);
    endtask

    // r, s, then each 16-byte chunk of the message as a little-endian number
    task automatic build_exp(input logic [255:0] k, input int n);
        logic [127:0] v;
        exp_q.delete();
        exp_q.push_back(r_of(k));
        exp_q.push_back(k[255:128]);
        for (int b = 0; b * 16 < n; b++) begin
            v = '0;
            for (int i = 0; i < 16 && (b * 16 + i) < n; i++) v[8*i +: 8] = mb[b*16 + i];
            exp_q.push_back(v);
        end
    endtask

    task automatic req_once(input string tag, input logic [127:0] exp, input bit last,
                            input int hold, output bit ok);
        int t;
        int dup;
        rqst = 1'b1;
        t    = 0;
        ok   = 1'b0;
        while (!ok && t < 400) begin
            @(negedge clk);
            t++;
            if (en_msg === 1'b1) ok = 1'b1;
        end
        check($sformatf("%s seen", tag), 128'(ok), 128'(1));
        if (ok) begin
            check($sformatf("%s data", tag), msg, exp);
            dup = 0;
            for (int j = 1; j <= hold; j++) begin
                @(negedge clk);
                if (en_msg !== 1'b0) dup++;
                if (j == 1 && last) begin
                    check($sformatf("%s done", tag), 128'(done), 128'(1));
                    check($sformatf("%s busy_off", tag), 128'(busy), 128'(0));
                end
            end
            check($sformatf("%s single", tag), 128'(dup), 128'(0));
        end
        rqst = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    // Called at a negedge with exp_q already built.
    task automatic run_msg(input string tag, input logic [255:0] k, input int n, input int hold);
        int nw;
        int nstrb;
        bit req_done;
        bit rdy_seen;
        nw       = (n + 3) / 4;
        nstrb    = exp_q.size();
        req_done = 1'b0;
        rdy_seen = 1'b0;
        key   = k;
        len   = 32'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key   = rand_key();
        len   = $urandom;
        check($sformatf("%s busy_on", tag), 128'(busy), 128'(1));
        check($sformatf("%s len", tag), 128'(len_out), 128'(n));
        fork
            begin
                int kk;
                int cyc;
                kk  = 0;
                cyc = 0;
                while (!req_done && cyc < 3000) begin
                    rdy_seen = rdy_seen | (wr_rdy === 1'b1);
                    if (kk < nw && wr_rdy === 1'b1) begin
                        wr_en   = ($urandom_range(0, 3) != 0);
                        wr_data = word_at(kk);
                        if (wr_en) kk++;
                    end else begin
                        wr_en   = ($urandom_range(0, 1) == 1);
                        wr_data = $urandom;
                    end
                    @(negedge clk);
                    cyc++;
                end
                wr_en = 1'b0;
            end
            begin
                bit ok;
                int h;
                for (int s = 0; s < nstrb; s++) begin
                    h = (hold > 0) ? hold : int'($urandom_range(1, 3));
                    req_once($sformatf("%s s%0d", tag, s), exp_q[s], (s == nstrb - 1), h, ok);
                    if (!ok) break;
                end
                req_done = 1'b1;
            end
        join
        check($sformatf("%s wr_rdy_seen", tag), 128'(rdy_seen), 128'(n > 0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] k;
        string        txt;
        bit           ok;
        int           dup;
        int           lens [8] = '{1, 4, 15, 16, 32, 33, 63, 64};

        rst = 1'b1; start = 1'b0; key = '0; len = '0;
        wr_en = 1'b0; wr_data = '0; rqst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst en_msg",  128'(en_msg),  128'(0));
        check("rst msg",     msg,           128'(0));
        check("rst len_out", 128'(len_out), 128'(0));
        check("rst wr_rdy",  128'(wr_rdy),  128'(0));
        check("rst busy",    128'(busy),    128'(0));
        check("rst done",    128'(done),    128'(0));
        rst = 1'b0;
        @(negedge clk);

        // RFC 8439 vector with literal expectations
        fill_msg();
        txt = "Cryptographic Forum Research Group";
        for (int i = 0; i < 34; i++) mb[i] = txt[i];
        k = {128'h1bf54941_aff6bf4a_fdb20dfb_8a800301, 128'ha806d542_fe52447f_336d5557_78bed685};
        exp_q.delete();
`ifdef P_FEED_CLAMP_EN
        exp_q.push_back(128'h0806d540_0e52447c_036d5554_08bed685);
`else
        exp_q.push_back(128'ha806d542_fe52447f_336d5557_78bed685);
`endif
        exp_q.push_back(128'h1bf54941_aff6bf4a_fdb20dfb_8a800301);
        exp_q.push_back(128'h6f462063_69687061_72676f74_70797243);
        exp_q.push_back(128'h6f724720_68637261_65736552_206d7572);
        exp_q.push_back(128'h00000000_00000000_00000000_00007075);
        run_msg("rfc", k, 34, 0);

        // Empty message: r, s, done, never ready for stream words
        k = rand_key();
        build_exp(k, 0);
        run_msg("len0", k, 0, 0);

        // Request level held for 5 cycles after each strobe
        fill_msg();
        k = rand_key();
        build_exp(k, 20);
        run_msg("hold5", k, 20, 5);

        // len=17: final word carries junk above byte 16
        fill_msg();
        mb[16] = 8'hDD; mb[17] = 8'hCC; mb[18] = 8'hBB; mb[19] = 8'hAA;
        k = rand_key();
        build_exp(k, 17);
        exp_q[3] = 128'h000000DD;
        run_msg("len17", k, 17, 0);

        for (int t = 0; t < 12; t++) begin
            int n;
            n = (t < 8) ? lens[t] : int'($urandom_range(1, 100));
            fill_msg();
            k = rand_key();
            build_exp(k, n);
            run_msg($sformatf("rnd%0d_len%0d", t, n), k, n, 0);
        end

        // Reset in FILL after two words, with a pending request
        fill_msg();
        k = rand_key();
        build_exp(k, 40);
        key = k; len = 32'd40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        req_once("mid r", exp_q[0], 1'b0, 1, ok);
        req_once("mid s", exp_q[1], 1'b0, 1, ok);
        check("mid rdy0", 128'(wr_rdy), 128'(1));
        wr_en = 1'b1; wr_data = word_at(0);
        @(negedge clk);
        check("mid rdy1", 128'(wr_rdy), 128'(1));
        wr_data = word_at(1);
        @(negedge clk);
        wr_en = 1'b0;
        rqst  = 1'b1;
        repeat (2) @(negedge clk);
        check("mid no_strobe_in_fill", 128'(en_msg), 128'(0));
        #1 rst = 1'b1;
        #1;
        check("mid rst en_msg",  128'(en_msg),  128'(0));
        check("mid rst msg",     msg,           128'(0));
        check("mid rst len_out", 128'(len_out), 128'(0));
        check("mid rst wr_rdy",  128'(wr_rdy),  128'(0));
        check("mid rst busy",    128'(busy),    128'(0));
        check("mid rst done",    128'(done),    128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dup = 0;
        repeat (10) begin
            @(negedge clk);
            if (en_msg !== 1'b0) dup++;
        end
        check("mid no_strobe_after_rst", 128'(dup), 128'(0));
        rqst = 1'b0;
        @(negedge clk);

        fill_msg();
        k = rand_key();
        build_exp(k, 40);
        run_msg("after_rst", k, 40, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/p_msg_feed.md
# p_msg_feed

Message supplier for the Poly1305 tag engine `p_tag`. It answers each `o_rqst_msg` request from `p_tag` with a single-cycle `i_en_msg` strobe and a 128-bit word. The words go out in a fixed order: key r, then key s, then the message in 16-byte little-endian blocks, with the last block zero-padded. It takes the one-time key from the ChaCha20 block-0 output and the message as a 32-bit word stream. It sits between the ChaCha20 core and `p_tag` in the AEAD datapath.

## Interface
Parameters:
- none (block size fixed at 128 bits; stream word fixed at 32 bits)

Ports (one clock `i_clk`; reset `i_rst` is asynchronous and active-high):
- `i_clk`  in  1  clock
- `i_rst`  in  1  async active-high reset
- `i_start`  in  1  one-cycle pulse; latches `i_key` and `i_len_msg`
- `i_key`  in  256  {s[127:0], r[127:0]}; r in [127:0]
- `i_len_msg`  in  32  message length in bytes
- `i_wr_en`  in  1  stream word valid
- `i_wr_data`  in  32  stream word; byte n at [8n+7:8n]
- `o_wr_rdy`  out  1  feeder accepts a stream word this cycle
- `i_rqst_msg`  in  1  request level from `p_tag`
- `o_en_msg`  out  1  one-cycle data strobe to `p_tag`
- `o_msg`  out  128  data to `p_tag`
- `o_len_msg`  out  32  latched length, forwarded to `p_tag`
- `o_busy`  out  1  high from `i_start` until `o_done`
- `o_done`  out  1  one-cycle pulse after the last block is sent

## Operation
- FSM states: IDLE, KEY_R, KEY_S, FILL, READY, DONE.
- IDLE: `i_start` latches key and length and goes to KEY_R. `i_start` is ignored in every other state.
- KEY_R: waits for a request edge, sends r, goes to KEY_S.
- KEY_S: waits for a request edge, sends s. Then goes to FILL, or to DONE if `len==0`.
- FILL: accepts words (`o_wr_rdy=1`). Word k is placed at `o_msg[32*(k%4)+31:32*(k%4)]`. Goes to READY when 4 words are packed, or when the final word of the message arrives.
- READY: `o_wr_rdy=0`. On a request edge it sends the block, clears the pack register, and returns to FILL. After the last block it goes to DONE instead.
- DONE: pulses `o_done` for one cycle, then goes to IDLE.
- Block count is ceil(len/16). Stream word count is ceil(len/4).
- Padding: in the last block, every byte at index ≥ `len%16` is forced to 0; this includes bytes inside the final word. Junk in unused stream bytes never reaches `o_msg`.
- Request edge: `i_rqst_msg` is high this cycle and the request has not already been served. A request stays served until `i_rqst_msg` returns low. One request produces exactly one strobe.
- `i_wr_en` while `o_wr_rdy=0` is dropped and has no effect.

## Timing
- Reset values: `o_en_msg=0`, `o_msg=0`, `o_len_msg=0`, `o_wr_rdy=0`, `o_busy=0`, `o_done=0`, FSM=IDLE, request-served flag cleared.
- `o_busy` rises the cycle after `i_start`.
- `o_en_msg` is registered. It rises the cycle after a request edge is sampled, provided the data is ready.
- `o_msg` is valid exactly in the `o_en_msg` cycle and holds its value until the next strobe.
- If a request arrives while in FILL, the strobe is issued the cycle after READY is reached; the request edge is not lost.
- Throughput: 4 stream cycles per block plus 1 cycle to send, minimum.
- `o_done` is asserted the cycle after the final strobe; `o_busy` falls in the same cycle.
- `i_rst` mid-message: all state is cleared immediately. A partial block is discarded and never sent.

## Configuration
- `P_FEED_CLAMP_EN` defined: r is ANDed with 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff before it is sent.
- `P_FEED_CLAMP_EN` undefined: r is sent raw and `p_tag` does the clamping.
- s and the message path are identical in both builds.

## Structure
- Shared package `p_pkg`:
  - FSM state encoding
  - r clamp mask constant
  - block byte count 16 and words-per-block 4
- One sub-module, `p_blk_pack`:
  - 4-word pack register with word index
  - byte-mask generation from `len%16`
  - clear on send
- The FSM, request edge detect and output registers stay in `p_msg_feed`.

## Test plan
- RFC 8439 key, `len=34`, message "Cryptographic Forum Research Group", first word 32'h70797243. Required responses:
  - strobe 1 = 128'ha806d542_fe52447f_336d5557_78bed685 (unclamped build)
  - strobe 2 = 128'h1bf54941_aff6bf4a_fdb20dfb_8a800301
  - strobe 3 = 128'h6f462063_69687061_72676f74_70797243
  - strobe 4 = 128'h6f724720_68637261_65736552_206d7572
  - strobe 5 = 128'h00000000_00000000_00000000_00007075
  - `o_done` after strobe 5
- Same key with `P_FEED_CLAMP_EN` defined -> strobe 1 = 128'h0806d540_0e52447c_036d5554_08bed685.
- `len=0` -> only 2 strobes (r, s), then `o_done`. `o_wr_rdy` stays 0 throughout.
- `i_rqst_msg` held high for 5 cycles -> exactly one `o_en_msg`. A second strobe comes only after `i_rqst_msg` drops and rises again.
- `len=17`, last stream word 32'hAABBCCDD -> last block = 128'h000000DD. `o_wr_rdy` drops during READY, and `i_wr_en` pulses sent then are ignored.
- `i_rst` asserted in FILL after 2 words -> all outputs return to 0 at once, and no strobe follows. A new `i_start` runs the full sequence again from r.
